// File: rtl/button_pkg.sv
// Shared constants and width helper for the button debounce block.
package button_pkg;

    localparam int TICK_DIV_DEFAULT     = 2097152;
    localparam int STABLE_TICKS_DEFAULT = 3;
    localparam int LONG_TICKS_DEFAULT   = 0;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Pin-side inputs and debounced per-channel outputs.
interface button_debounce_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_evt;
    logic [N_CH-1:0] long_press;
    logic            tick;

    modport master (
        output btn,
        input  level, press, release_evt, long_press, tick
    );

    modport slave (
        input  btn,
        output level, press, release_evt, long_press, tick
    );
endinterface

// File: rtl/debounce_channel.sv
// One button: synchroniser, stability counter, hold counter and event pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int LONG_TICKS   = LONG_TICKS_DEFAULT,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_evt,
    output logic long_press
);
    localparam int   SW   = cnt_width(STABLE_TICKS);
    localparam logic IDLE = 1'(ACTIVE_LOW);

    logic [1:0]    sync;
    logic [SW-1:0] stab_cnt;
    logic          sample;
    logic          accept;

    assign sample = sync[1] ^ IDLE;
    assign accept = tick && (sample != level)
                    && (stab_cnt == SW'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{IDLE}};
        end else begin
            sync <= {sync[0], btn};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt    <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            press       <= 1'b0;
            release_evt <= 1'b0;
            if (tick) begin
                if (sample == level) begin
                    stab_cnt <= '0;
                end else if (accept) begin
                    stab_cnt    <= '0;
                    level       <= sample;
                    press       <= sample;
                    release_evt <= ~sample;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end
        end
    end

    generate
        if (LONG_TICKS > 0) begin : g_long
            localparam int HW = cnt_width(LONG_TICKS + 1);
            logic [HW-1:0] hold_cnt;
            logic          lp_q;

            // Saturation at LONG_TICKS makes the pulse fire once per press.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                    lp_q     <= 1'b0;
                end else begin
                    lp_q <= 1'b0;
                    if (tick) begin
                        if (!level || accept) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt != HW'(LONG_TICKS)) begin
                            hold_cnt <= hold_cnt + 1'b1;
                            lp_q <= (hold_cnt == HW'(LONG_TICKS - 1));
                        end
                    end
                end
            end

            assign long_press = lp_q;
        end else begin : g_no_long
            assign long_press = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/button_debounce.sv
// N-channel debouncer sharing one sample-tick prescaler.
module button_debounce
    import button_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int LONG_TICKS   = LONG_TICKS_DEFAULT,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debounce_if.slave    bus
);
    localparam int PW = cnt_width(TICK_DIV);

    logic [PW-1:0] cnt;
    logic          tick_q;

    // tick_q is registered one count early so it lines up with the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= (cnt == PW'(TICK_DIV - 1)) ? '0 : cnt + 1'b1;
            tick_q <= (cnt == PW'(TICK_DIV - 2));
        end
    end

    assign bus.tick = tick_q;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            debounce_channel #(
                .STABLE_TICKS (STABLE_TICKS),
                .LONG_TICKS   (LONG_TICKS),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .tick        (tick_q),
                .btn         (bus.btn[g]),
                .level       (bus.level[g]),
                .press       (bus.press[g]),
                .release_evt (bus.release_evt[g]),
                .long_press  (bus.long_press[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: two instances, active-high and active-low.
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    button_debounce_if #(.N_CH(2)) bif ();
    button_debounce_if #(.N_CH(2)) abif ();

    button_debounce #(
        .N_CH(2), .TICK_DIV(4), .STABLE_TICKS(3),
        .LONG_TICKS(5), .ACTIVE_LOW(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    button_debounce #(
        .N_CH(2), .TICK_DIV(4), .STABLE_TICKS(3),
        .LONG_TICKS(5), .ACTIVE_LOW(1)
    ) dut_al (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (abif.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs,
                           input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [8:0] outs_a();
        return {bif.level, bif.press, bif.release_evt, bif.long_press, bif.tick};
    endfunction

    function automatic logic [8:0] outs_b();
        return {abif.level, abif.press, abif.release_evt, abif.long_press, abif.tick};
    endfunction

    initial begin
        int n;
        int m;
        int cnt_ev;
        logic [1:0] ev;

        bif.btn  = 2'b00;
        abif.btn = 2'b11;

        // Reset held with toggling buttons
        for (int i = 0; i < 4; i++) begin
            step();
            bif.btn  = ~bif.btn;
            abif.btn = ~abif.btn;
            chk("reset_outs_a", 32'(outs_a()), 32'h0);
            chk("reset_outs_b", 32'(outs_b()), 32'h0);
        end
        bif.btn  = 2'b00;
        abif.btn = 2'b11;
        step();
        rst_n = 1'b1;

        // First tick during the 4th cycle after release
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("first_tick_c%0d", i), 32'(bif.tick), 32'(i == 3));
        end

        // Clean press on ch0
        bif.btn[0] = 1'b1;
        n = 0;
        while (!bif.level[0] && n < 30) begin
            step();
            n++;
        end
        chk_rng("press_latency", n, 11, 14);
        chk("press_pulse", 32'(bif.press), 32'h1);
        chk("press_level", 32'(bif.level), 32'h1);
        chk("press_no_release", 32'(bif.release_evt), 32'h0);
        step();
        m = 1;
        chk("press_one_clk", 32'(bif.press), 32'h0);

        // Long press
        while (!bif.long_press[0] && m < 40) begin
            step();
            m++;
        end
        chk_rng("long_latency", m, 16, 24);
        chk("long_pulse", 32'(bif.long_press), 32'h1);
        cnt_ev = 0;
        repeat (24) begin
            step();
            if (bif.long_press != 2'b00) cnt_ev++;
        end
        chk("long_once", 32'(cnt_ev), 32'h0);

        // Release
        bif.btn[0] = 1'b0;
        n = 0;
        cnt_ev = 0;
        while (!bif.release_evt[0] && n < 30) begin
            step();
            n++;
            if (bif.long_press != 2'b00) cnt_ev++;
        end
        chk_rng("release_latency", n, 11, 14);
        chk("release_pulse", 32'(bif.release_evt), 32'h1);
        chk("release_no_press", 32'(bif.press), 32'h0);
        chk("release_level", 32'(bif.level), 32'h0);
        step();
        chk("release_one_clk", 32'(bif.release_evt), 32'h0);
        chk("release_no_long", 32'(cnt_ev), 32'h0);

        // Glitch: 8 clk high, then bounce at tick rate
        repeat (8) step();
        ev = 2'b00;
        bif.btn[0] = 1'b1;
        repeat (8) begin
            step();
            ev |= bif.level | bif.press | bif.release_evt;
        end
        bif.btn[0] = 1'b0;
        repeat (16) begin
            step();
            ev |= bif.level | bif.press | bif.release_evt;
        end
        chk("glitch_8clk", 32'(ev), 32'h0);
        ev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            bif.btn[0] = (k % 2 == 0);
            repeat (4) begin
                step();
                ev |= bif.level | bif.press | bif.release_evt;
            end
        end
        bif.btn[0] = 1'b0;
        repeat (16) begin
            step();
            ev |= bif.level | bif.press | bif.release_evt;
        end
        chk("glitch_bounce", 32'(ev), 32'h0);

        // Active-low, both channels together
        abif.btn = 2'b00;
        n = 0;
        while (abif.level == 2'b00 && n < 30) begin
            step();
            n++;
        end
        chk_rng("al_latency", n, 11, 14);
        chk("al_press", 32'(abif.press), 32'h3);
        chk("al_level", 32'(abif.level), 32'h3);

        // Async reset mid-press
        bif.btn[0] = 1'b1;
        n = 0;
        while (!bif.level[0] && n < 30) begin
            step();
            n++;
        end
        chk("pre_reset_level", 32'(bif.level), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_level_a", 32'(bif.level), 32'h0);
        chk("async_level_b", 32'(abif.level), 32'h0);
        bif.btn  = 2'b00;
        abif.btn = 2'b11;
        step();
        step();
        rst_n = 1'b1;
        ev = 2'b00;
        repeat (30) begin
            step();
            ev |= bif.release_evt | abif.release_evt
                  | bif.press | abif.press;
        end
        chk("no_release_after_reset", 32'(ev), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
